score_scan_driver: RTL and testbench

Upstream feeder for the team's seven-segment decoder on the four-digit display. Accepts a 14-bit binary score on a load pulse and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. Time-multiplexes those digits onto the shared segment bus, producing the 4-bit digit code that drives the decoder and the matching active-low anode enables. Decoder input codes 10–15 blank the display; this block uses 4'hF as its blank code.

---
 rtl/score_scan_driver.sv | 122 ++++++++++++
 tb/tb_score_scan_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/score_scan_driver.sv
// rtl/score_scan_driver.sv - 14-bit score to BCD converter with four-digit multiplexed scan.
// Optional macro SCAN_BLANK_EN enables leading-zero blanking.
module score_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  digit,
    output logic [3:0]  an
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [13:0]    bin_q, bin_d;
    logic [15:0]    bcd_q, bcd_d;
    logic [3:0]     iter_q, iter_d;
    logic [15:0]    disp_q, disp_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    adj;
    logic [3:0]     raw_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Add-3 correction applied before each shift keeps every nibble a valid BCD digit.
    always_comb begin
        adj = '0;
        for (int k = 0; k < 4; k++) begin
            adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = (value > 14'd9999) ? 14'd9999 : value;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d  = {adj[14:0], bin_q[13]};
                bin_d  = {bin_q[12:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scan, deliberately independent of conversion activity.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    assign busy      = (state_q != IDLE);
    assign an        = ~(4'b0001 << idx_q);
    assign raw_digit = disp_q[4*idx_q +: 4];

`ifdef SCAN_BLANK_EN
    logic [1:0] msd;

    always_comb begin
        msd = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (disp_q[4*k +: 4] != 4'd0) begin
                msd = 2'(k);
            end
        end
    end

    assign digit = (idx_q > msd) ? 4'hF : raw_digit;
`else
    assign digit = raw_digit;
`endif

endmodule

// File: tb/tb_score_scan_driver.sv
// tb/tb_score_scan_driver.sv - Self-checking bench for score_scan_driver with REFRESH_DIV=4.
module tb_score_scan_driver;
    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic [3:0]  digit;
    logic [3:0]  an;

    int total;
    int bad;
    int e;
    logic [15:0] cur;

    score_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .load  (load),
        .busy  (busy),
        .digit (digit),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since reset release; the scan position follows from this alone.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) e <= 0;
        else        e <= e + 1;
    end

`ifdef SCAN_BLANK_EN
    localparam logic [3:0] Z = 4'hF;
`else
    localparam logic [3:0] Z = 4'h0;
`endif

    typedef struct {
        int          val;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [15:0] model(int v);
        int sat;
        int pw;
        logic [15:0] r;
        sat = (v > 9999) ? 9999 : v;
        pw  = 1;
        r   = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'((sat / pw) % 10);
`ifdef SCAN_BLANK_EN
            if (k > 0 && sat < pw) r[4*k +: 4] = 4'hF;
`endif
            pw = pw * 10;
        end
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(string tag, logic [15:0] shown);
        int ix;
        logic [3:0] a;
        ix = (e / DIV) % 4;
        a  = ~(4'b0001 << ix);
        chk({tag, " an"}, int'(an), int'(a));
        chk({tag, " digit"}, int'(digit), int'(shown[4*ix +: 4]));
    endtask

    task automatic scan(string tag);
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            chk_out(tag, cur);
        end
    endtask

    // Issues a load and checks busy, the old display during conversion, and the new one after.
    task automatic do_load(string tag, int v, logic [15:0] expd, int extra_at, int extra_val);
        logic [15:0] old;
        old = cur;
        @(negedge clk);
        value = 14'(v);
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk({tag, " busy high"}, int'(busy), 1);
            chk_out({tag, " hold"}, old);
            if (i == extra_at) begin
                value = 14'(extra_val);
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk({tag, " busy low"}, int'(busy), 0);
        cur = expd;
        chk_out({tag, " new"}, cur);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        tbl[0] = '{1234,  16'h1234};
        tbl[1] = '{42,    {Z, Z, 4'h4, 4'h2}};
        tbl[2] = '{0,     {Z, Z, Z, 4'h0}};
        tbl[3] = '{12000, 16'h9999};
        tbl[4] = '{9999,  16'h9999};
        tbl[5] = '{10000, 16'h9999};
        tbl[6] = '{1000,  16'h1000};
        tbl[7] = '{16383, 16'h9999};

        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset an", int'(an), 'he);
        chk("reset digit", int'(digit), 0);
        rst_n = 1'b1;
        cur = model(0);
        scan("after reset");

        for (int t = 0; t < 8; t++) begin
            do_load($sformatf("tbl%0d", t), tbl[t].val, tbl[t].exp, -1, 0);
            scan($sformatf("tbl%0d scan", t));
        end

        do_load("overlap", 5678, 16'h5678, 2, 1111);
        scan("overlap scan");

        do_load("commit edge", 1234, 16'h1234, 14, 4321);
        @(negedge clk);
        chk("commit edge load dropped", int'(busy), 0);
        scan("commit edge scan");

        for (int r = 0; r < 20; r++) begin
            int v;
            v = (r % 4 == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 16383));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_load($sformatf("rand%0d v=%0d", r, v), v, model(v), -1, 0);
            scan($sformatf("rand%0d scan", r));
        end

        @(negedge clk);
        value = 14'd9876;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort an", int'(an), 'he);
        chk("abort digit", int'(digit), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur = model(0);
        scan("abort scan");
        @(negedge clk);
        chk("abort stays idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
